// File: rtl/ccff_pkg.sv
// Shared FSM state type and CRC-8 constants for the ccff chain loader.
// Defining CCFF_LOADER_VERIFY_EN adds the VERIFY state used for readback checking.
package ccff_pkg;

`ifdef CCFF_LOADER_VERIFY_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      VERIFY = 2'd2,
      DONE   = 2'd3
   } ccff_state_t;
`else
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      DONE   = 2'd3
   } ccff_state_t;
`endif

   localparam logic [7:0] CRC8_POLY = 8'h07;
   localparam logic [7:0] CRC8_INIT = 8'h00;

   // One serial CRC-8 step, MSB-first feedback.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
      logic fb;
      fb = crc[7] ^ b;
      return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/ccff_crc8.sv
// Serial CRC-8 accumulator: one bit per enabled clock, synchronous clear to init.
module ccff_crc8
   import ccff_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic       i_bit,
   output logic [7:0] o_crc
);

   logic [7:0] r_crc;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_crc <= CRC8_INIT;
      end else if (i_clr) begin
         r_crc <= CRC8_INIT;
      end else if (i_en) begin
         r_crc <= crc8_step(r_crc, i_bit);
      end
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/ccff_loader.sv
// Streams bitstream words LSB-first into a ccff configuration chain.
// With CCFF_LOADER_VERIFY_EN the chain is rotated once more and its CRC compared.
//
// state  | meaning
// IDLE   | waiting for start; counters, buffer and err cleared on start
// LOAD   | accepting words and shifting CHAIN_LEN bits into the chain
// VERIFY | rotating the chain through itself, one shift every other cycle
// DONE   | one-cycle done pulse, err valid
module ccff_loader
   import ccff_pkg::*;
#(
   parameter int CHAIN_LEN = 18,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              pReset_n,
   input  logic              start,
   input  logic [WORD_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CW = $clog2(((CHAIN_LEN > WORD_W) ? CHAIN_LEN : WORD_W) + 1);
   localparam logic [CW-1:0] LEN_C  = CW'(CHAIN_LEN);
   localparam logic [CW-1:0] WORD_C = CW'(WORD_W);
   localparam logic [CW-1:0] ONE_C  = CW'(1);

   ccff_state_t       r_state;
   logic [CW-1:0]     r_bit_cnt;
   logic [CW-1:0]     r_bits_left;
   logic [CW-1:0]     r_buf_cnt;
   logic [WORD_W-1:0] r_buf;
   logic              r_head;
   logic              r_shift_en;
   logic              r_done;
   logic              w_ready;
   logic              w_last_shift;
   logic [CW-1:0]     w_word_bits;

   // Buffer is "empty" once its last bit is on ccff_head, so words chain with no gap.
   assign w_ready      = (r_state == LOAD) && (r_buf_cnt == '0) && (r_bits_left != '0);
   assign w_last_shift = r_shift_en && (r_bit_cnt == ONE_C);
   assign w_word_bits  = (r_bits_left > WORD_C) ? WORD_C : r_bits_left;

`ifdef CCFF_LOADER_VERIFY_EN
   logic       r_err;
   logic [7:0] w_crc_load;
   logic [7:0] w_crc_ver;
   logic       w_crc_clr;

   assign w_crc_clr = (r_state == IDLE) && start;

   ccff_crc8 u_crc_load (
      .i_clk   (prog_clk),
      .i_rst_n (pReset_n),
      .i_clr   (w_crc_clr),
      .i_en    ((r_state == LOAD) && r_shift_en),
      .i_bit   (r_head),
      .o_crc   (w_crc_load)
   );

   ccff_crc8 u_crc_ver (
      .i_clk   (prog_clk),
      .i_rst_n (pReset_n),
      .i_clr   (w_crc_clr),
      .i_en    ((r_state == VERIFY) && r_shift_en),
      .i_bit   (ccff_tail),
      .o_crc   (w_crc_ver)
   );
`else
   logic w_unused_tail;
   assign w_unused_tail = ccff_tail;
`endif

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         r_state     <= IDLE;
         r_bit_cnt   <= '0;
         r_bits_left <= '0;
         r_buf_cnt   <= '0;
         r_buf       <= '0;
         r_head      <= 1'b0;
         r_shift_en  <= 1'b0;
         r_done      <= 1'b0;
`ifdef CCFF_LOADER_VERIFY_EN
         r_err       <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_shift_en <= 1'b0;
               r_head     <= 1'b0;
               if (start) begin
                  r_state     <= LOAD;
                  r_bit_cnt   <= LEN_C;
                  r_bits_left <= LEN_C;
                  r_buf_cnt   <= '0;
                  r_buf       <= '0;
`ifdef CCFF_LOADER_VERIFY_EN
                  r_err       <= 1'b0;
`endif
               end
            end
            LOAD: begin
               if (r_shift_en) begin
                  r_bit_cnt <= r_bit_cnt - ONE_C;
               end
               if (w_last_shift) begin
                  r_shift_en <= 1'b0;
                  r_head     <= 1'b0;
`ifdef CCFF_LOADER_VERIFY_EN
                  r_state    <= VERIFY;
                  r_bit_cnt  <= LEN_C;
`else
                  r_state    <= DONE;
                  r_done     <= 1'b1;
`endif
               end else if (r_buf_cnt != '0) begin
                  r_head     <= r_buf[0];
                  r_buf      <= r_buf >> 1;
                  r_buf_cnt  <= r_buf_cnt - ONE_C;
                  r_shift_en <= 1'b1;
               end else if (din_valid && w_ready) begin
                  // Only the bits still owed to the chain are kept; the rest are dropped.
                  r_head      <= din[0];
                  r_buf       <= din >> 1;
                  r_buf_cnt   <= w_word_bits - ONE_C;
                  r_bits_left <= r_bits_left - w_word_bits;
                  r_shift_en  <= 1'b1;
               end else begin
                  r_shift_en <= 1'b0;
               end
            end
`ifdef CCFF_LOADER_VERIFY_EN
            // Head is registered, so each rotation step waits a cycle for the tail to settle.
            VERIFY: begin
               if (r_shift_en) begin
                  r_shift_en <= 1'b0;
                  r_bit_cnt  <= r_bit_cnt - ONE_C;
               end else if (r_bit_cnt == '0) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                  r_head  <= 1'b0;
                  r_err   <= (w_crc_load != w_crc_ver);
               end else begin
                  r_head     <= ccff_tail;
                  r_shift_en <= 1'b1;
               end
            end
`endif
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state    <= IDLE;
               r_shift_en <= 1'b0;
            end
         endcase
      end
   end

   assign din_ready     = w_ready;
   assign ccff_head     = r_head;
   assign ccff_shift_en = r_shift_en;
   assign done          = r_done;
`ifdef CCFF_LOADER_VERIFY_EN
   assign busy = (r_state == LOAD) || (r_state == VERIFY);
   assign err  = r_err;
`else
   assign busy = (r_state == LOAD);
   assign err  = 1'b0;
`endif

endmodule
